fft_output_unloader: RTL and testbench
======================================

FFT_OUTPUT_UNLOADER -- requirements
Module: fft_output_unloader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each real/imag component.
REQ-002 SHALL have parameter BITREV_OUT, default 0; 0 streams natural order, 1 streams bit-reversed order.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse meaning the 64-point FFT result is complete in both banks.
REQ-006 SHALL have ports re_b0, re_b1  output  1  bank read enables.
REQ-007 SHALL have ports raddr_b0, raddr_b1  output  5  bank read addresses.
REQ-008 SHALL have ports rdata_b0, rdata_b1  input  2*DATA_W  bank read data as {real, imag}, valid one cycle after re.
REQ-009 SHALL have port out_valid  output  1  out_data, out_index and out_last are valid.
REQ-010 SHALL have port out_ready  input  1  the downstream consumer accepts the sample.
REQ-011 SHALL have port out_data  output  2*DATA_W  the complex sample {real, imag}.
REQ-012 SHALL have port out_index  output  6  frequency bin of out_data, 0..63.
REQ-013 SHALL have port out_last  output  1  high with the sample of stream position 63.
REQ-014 SHALL have port busy  output  1  an unload is in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse when an unload completes.

Function
REQ-016 SHALL map a point index p[5:0] to bank = XOR of p[5:0] (0 selects b0) and address = p[5:1].
REQ-017 SHALL set, for stream position k, p = k when BITREV_OUT=0 and p = bit-reverse(k) when BITREV_OUT=1; out_index SHALL equal p.
REQ-018 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN after issuing read k=63; DRAIN -> IDLE on the handshake of out_last.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL assert at most one of re_b0/re_b1 per cycle; the non-selected bank's re SHALL be 0 and its raddr SHALL be 0.
REQ-021 SHALL capture read data into a 2-entry output FIFO, using the bank select registered with the issuing read to choose rdata_b0 or rdata_b1.
REQ-022 SHALL issue a read in RUN only when FIFO count + reads in flight - (out_valid AND out_ready) < 2, so the FIFO never overflows.
REQ-023 SHALL sustain one sample per cycle while out_ready=1; minimum latency from start to first out_valid SHALL be 2 cycles.
REQ-024 SHALL hold out_data, out_index and out_last stable while out_valid=1 and out_ready=0.
REQ-025 SHALL count a transfer only on a cycle with out_valid=1 and out_ready=1.
REQ-026 SHALL set busy=1 from the cycle after start is accepted until the cycle after the out_last handshake.
REQ-027 SHALL pulse done exactly one cycle, on the cycle after the out_last handshake, coincident with busy falling.
REQ-028 SHALL accept a start that arrives in the same cycle that done is high, beginning a new unload with no gap.
REQ-029 SHALL wrap the stream counter from 63 to 0 only via an IDLE->RUN transition, never within one unload.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, go to IDLE, flush the FIFO, discard reads in flight and clear the counter.
REQ-031 SHALL drive out_valid, out_last, busy, done, re_b0 and re_b1 to 0, and out_data, out_index, raddr_b0 and raddr_b1 to 0, while rst=1 and until the next accepted start.
REQ-032 SHALL give rst priority over start in the same cycle; a reset mid-unload SHALL abort the unload with no done pulse.

Structure
REQ-033 SHALL take the FFT size constants (N=64, LOG2N=6, bank depth 32) and the point-to-bank/address mapping function from the shared FFT package, alongside the control block's definitions.
REQ-034 SHALL implement the 2-entry output FIFO as sub-module fft_out_skid; address generation and the FSM SHALL remain in the top module.

Verification
REQ-035 Preload b0/b1 with value = point index using the REQ-016 mapping, out_ready=1, pulse start -> out_index/out_data 0..63 on 64 consecutive cycles, first out_valid 2 cycles after start, out_last at 63, done one cycle later.
REQ-036 With BITREV_OUT=1 and the same preload -> out_index sequence 0,32,16,48,8,... with out_data equal to out_index throughout.
REQ-037 Toggle out_ready randomly at 50% -> exactly 64 transfers in order, data stable while stalled, never more than 2 reads outstanding beyond FIFO space.
REQ-038 Assert rst while out_index = 20 is pending -> next cycle out_valid=0, busy=0, no done pulse; a fresh start streams again from index 0.
REQ-039 Pulse start at position 30 mid-unload -> no effect; pulse start on the done cycle -> second unload starts immediately.
REQ-040 Check every cycle -> re_b0 AND re_b1 never both 1, and bank/address match the REQ-016 mapping for the current point index.

Source files
------------

// File: rtl/fft_output_unloader_pkg.sv
// Shared FFT definitions: size constants, unload control states and the
// point-index to memory-bank mapping used by the result banks.
package fft_output_unloader_pkg;

  localparam int unsigned FFT_N      = 64;
  localparam int unsigned FFT_LOG2N  = 6;
  localparam int unsigned BANK_DEPTH = 32;
  localparam int unsigned BANK_AW    = 5;

  typedef logic [FFT_LOG2N-1:0] point_t;
  typedef logic [BANK_AW-1:0]   bank_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } unload_state_t;

  // Parity of the point index picks the bank, so butterfly partners never collide.
  function automatic logic point_bank(input point_t p);
    return ^p;
  endfunction

  function automatic bank_addr_t point_addr(input point_t p);
    return p[FFT_LOG2N-1:1];
  endfunction

  function automatic point_t bit_reverse(input point_t k);
    point_t r;
    r = '0;
    for (int unsigned i = 0; i < FFT_LOG2N; i++) begin
      r[i] = k[FFT_LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_skid.sv
// Two-entry output FIFO holding {last, index, sample} between the bank reads
// and the downstream valid/ready port.
module fft_out_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign valid = (cnt != '0);
  assign data  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/fft_output_unloader.sv
// Streams a completed 64-point FFT result out of two parity-interleaved banks
// in natural or bit-reversed order through a valid/ready port.
module fft_output_unloader
  import fft_output_unloader_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter bit          BITREV_OUT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  re_b0,
  output logic                  re_b1,
  output logic [BANK_AW-1:0]    raddr_b0,
  output logic [BANK_AW-1:0]    raddr_b1,
  input  logic [2*DATA_W-1:0]   rdata_b0,
  input  logic [2*DATA_W-1:0]   rdata_b1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   out_data,
  output logic [FFT_LOG2N-1:0]  out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned SAMPLE_W = 2 * DATA_W;
  localparam int unsigned ENTRY_W  = SAMPLE_W + FFT_LOG2N + 1;

  unload_state_t state, state_next;
  point_t        k, k_issue, p;
  logic          accept, issue, last_issue;
  logic          handshake, last_handshake;
  logic          sel_bank;
  bank_addr_t    sel_addr;
  logic          pend, pend_bank, pend_last;
  point_t        pend_p;
  logic          done_q;
  logic [2:0]    occupancy;

  logic                fifo_valid;
  logic [1:0]          fifo_count;
  logic [ENTRY_W-1:0]  push_entry, head_entry;
  logic                head_last;
  point_t              head_index;
  logic [SAMPLE_W-1:0] head_data;

  // Read 0 is issued in the start cycle itself; that is what gives the
  // two-cycle start-to-valid latency.
  assign accept     = (state == ST_IDLE) && start && !rst;
  assign k_issue    = (state == ST_IDLE) ? '0 : k;
  assign p          = BITREV_OUT ? bit_reverse(k_issue) : k_issue;
  assign occupancy  = 3'(fifo_count) + 3'(pend) - 3'(handshake);
  assign issue      = (accept || (state == ST_RUN && !rst)) && (occupancy < 3'd2);
  assign last_issue = issue && (k_issue == point_t'(FFT_N - 1));
  assign sel_bank   = point_bank(p);
  assign sel_addr   = point_addr(p);

  assign {head_last, head_index, head_data} = head_entry;
  assign handshake      = out_valid && out_ready;
  assign last_handshake = handshake && head_last;

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start)          state_next = ST_RUN;
      ST_RUN:   if (last_issue)     state_next = ST_DRAIN;
      ST_DRAIN: if (last_handshake) state_next = ST_IDLE;
      default:                      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      k         <= '0;
      pend      <= 1'b0;
      pend_bank <= 1'b0;
      pend_p    <= '0;
      pend_last <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (issue) k <= last_issue ? k_issue : k_issue + point_t'(1);
      pend      <= issue;
      pend_bank <= sel_bank;
      pend_p    <= p;
      pend_last <= last_issue;
      done_q    <= last_handshake;
    end
  end

  assign push_entry = {pend_last, pend_p, pend_bank ? rdata_b1 : rdata_b0};

  fft_out_skid #(.W(ENTRY_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (pend),
    .push_data (push_entry),
    .pop       (handshake),
    .valid     (fifo_valid),
    .data      (head_entry),
    .count     (fifo_count)
  );

  assign re_b0     = issue && !sel_bank;
  assign re_b1     = issue && sel_bank;
  assign raddr_b0  = re_b0 ? sel_addr : '0;
  assign raddr_b1  = re_b1 ? sel_addr : '0;
  assign out_valid = fifo_valid && !rst;
  assign out_data  = out_valid ? head_data  : '0;
  assign out_index = out_valid ? head_index : '0;
  assign out_last  = out_valid && head_last;
  assign busy      = (state != ST_IDLE) && !rst;
  assign done      = done_q && !rst;

endmodule

// File: tb/tb_fft_output_unloader.sv
// Directed bench: natural-order and bit-reversed instances share stimulus and
// are read from a common preloaded bank image.
module tb_fft_output_unloader;

  localparam int DW = 16;
  localparam int SW = 2 * DW;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  always #5 clk = ~clk;

  logic          re0_b0, re0_b1, v0, l0, busy0, done0;
  logic [4:0]    ra0_b0, ra0_b1;
  logic [SW-1:0] rd0_b0, rd0_b1, d0;
  logic [5:0]    i0;

  logic          re1_b0, re1_b1, v1, l1, busy1, done1;
  logic [4:0]    ra1_b0, ra1_b1;
  logic [SW-1:0] rd1_b0, rd1_b1, d1;
  logic [5:0]    i1;

  logic [SW-1:0] mem_b0 [32];
  logic [SW-1:0] mem_b1 [32];

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;

  fft_output_unloader #(.DATA_W(DW), .BITREV_OUT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .re_b0(re0_b0), .re_b1(re0_b1), .raddr_b0(ra0_b0), .raddr_b1(ra0_b1),
    .rdata_b0(rd0_b0), .rdata_b1(rd0_b1),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_index(i0),
    .out_last(l0), .busy(busy0), .done(done0)
  );

  fft_output_unloader #(.DATA_W(DW), .BITREV_OUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .re_b0(re1_b0), .re_b1(re1_b1), .raddr_b0(ra1_b0), .raddr_b1(ra1_b1),
    .rdata_b0(rd1_b0), .rdata_b1(rd1_b1),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_index(i1),
    .out_last(l1), .busy(busy1), .done(done1)
  );

  function automatic logic [SW-1:0] sample_of(input logic [5:0] p);
    return {DW'(p), DW'(p) ^ 16'hA5A5};
  endfunction

  function automatic logic [5:0] brev(input logic [5:0] k);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = k[5-i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (re0_b0) rd0_b0 <= mem_b0[ra0_b0];
    if (re0_b1) rd0_b1 <= mem_b1[ra0_b1];
    if (re1_b0) rd1_b0 <= mem_b0[ra1_b0];
    if (re1_b1) rd1_b1 <= mem_b1[ra1_b1];
  end

  // Bank-port monitor: exclusivity, idle addresses and natural-order mapping.
  initial begin
    logic [5:0] ep;
    logic       eb;
    logic [4:0] ea;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_cnt = 0;
      end else begin
        if (start && !busy0) rd_cnt = 0;
        checks++;
        if ((re0_b0 && re0_b1) || (re1_b0 && re1_b1) ||
            (!re0_b0 && ra0_b0 !== 5'd0) || (!re0_b1 && ra0_b1 !== 5'd0) ||
            (!re1_b0 && ra1_b0 !== 5'd0) || (!re1_b1 && ra1_b1 !== 5'd0)) begin
          errors++;
          $display("FAIL bank_port_exclusive t=%0t got re0=%b%b ra0=%0d/%0d re1=%b%b ra1=%0d/%0d required one re, idle raddr 0",
                   $time, re0_b1, re0_b0, ra0_b1, ra0_b0, re1_b1, re1_b0, ra1_b1, ra1_b0);
        end
        if (re0_b0 || re0_b1) begin
          ep = 6'(rd_cnt);
          eb = ^ep;
          ea = ep[5:1];
          checks++;
          if ({re0_b1, re0_b0, ra0_b1, ra0_b0} !== {eb, ~eb, eb ? ea : 5'd0, eb ? 5'd0 : ea}) begin
            errors++;
            $display("FAIL bank_mapping read=%0d got re=%b%b raddr=%0d/%0d required bank=%b addr=%0d",
                     rd_cnt, re0_b1, re0_b0, ra0_b1, ra0_b0, eb, ea);
          end
          rd_cnt++;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (3) tick;
    checks++;
    if ({v0, l0, busy0, done0, re0_b0, re0_b1, d0, i0, ra0_b0, ra0_b1,
         v1, l1, busy1, done1, re1_b0, re1_b1, d1, i1, ra1_b0, ra1_b1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b busy=%b done=%b re=%b%b idx=%0d required all 0",
               v0, busy0, done0, re0_b1, re0_b0, i0);
    end
    start = 1'b1;
    tick;
    checks++;
    if ({busy0, busy1, re0_b0, re0_b1} !== 4'b0) begin
      errors++;
      $display("FAIL reset_over_start got busy=%b re=%b%b required 0 00", busy0, re0_b1, re0_b0);
    end
    rst = 1'b0; start = 1'b0;
    repeat (3) tick;
    checks++;
    if ({v0, busy0, done0, re0_b0, re0_b1, d0, i0, ra0_b0, ra0_b1} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset got v=%b busy=%b done=%b required all 0", v0, busy0, done0);
    end
  endtask

  task automatic test_stream_orders;
    out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if ({v0, busy0, v1, busy1} !== 4'b0101) begin
      errors++;
      $display("FAIL first_cycle got v0=%b busy0=%b v1=%b busy1=%b required 0 1 0 1", v0, busy0, v1, busy1);
    end
    tick;
    for (int k = 0; k < 64; k++) begin
      logic [5:0] kk, bk;
      kk = 6'(k);
      bk = brev(kk);
      checks++;
      if ({v0, l0, i0, d0} !== {1'b1, kk == 6'd63, kk, sample_of(kk)}) begin
        errors++;
        $display("FAIL natural_pos%0d got v=%b last=%b idx=%0d data=%h required 1 %b %0d %h",
                 k, v0, l0, i0, d0, kk == 6'd63, kk, sample_of(kk));
      end
      checks++;
      if ({v1, l1, i1, d1} !== {1'b1, kk == 6'd63, bk, sample_of(bk)}) begin
        errors++;
        $display("FAIL bitrev_pos%0d got v=%b last=%b idx=%0d data=%h required 1 %b %0d %h",
                 k, v1, l1, i1, d1, kk == 6'd63, bk, sample_of(bk));
      end
      tick;
    end
    checks++;
    if ({done0, busy0, v0, done1, busy1, v1} !== 6'b100100) begin
      errors++;
      $display("FAIL done_pulse got done=%b busy=%b v=%b (bitrev %b %b %b) required 1 0 0",
               done0, busy0, v0, done1, busy1, v1);
    end
    tick;
    checks++;
    if ({done0, done1} !== 2'b00) begin
      errors++;
      $display("FAIL done_one_cycle got done0=%b done1=%b required 0 0", done0, done1);
    end
  endtask

  task automatic test_backpressure;
    int exp;
    logic stalled;
    logic [SW+7:0] held;
    exp = 0;
    stalled = 1'b0;
    held = '0;
    out_ready = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int cyc = 0; cyc < 2000 && exp < 64; cyc++) begin
      if (stalled) begin
        checks++;
        if ({v0, l0, i0, d0} !== held) begin
          errors++;
          $display("FAIL stall_hold got %h required %h", {v0, l0, i0, d0}, held);
        end
      end
      checks++;
      if (rd_cnt - exp > 2) begin
        errors++;
        $display("FAIL outstanding got %0d reads beyond transfers required <= 2", rd_cnt - exp);
      end
      out_ready = 1'($urandom_range(0, 1));
      if (v0 && out_ready) begin
        checks++;
        if ({l0, i0, d0} !== {exp == 63, 6'(exp), sample_of(6'(exp))}) begin
          errors++;
          $display("FAIL bp_transfer%0d got last=%b idx=%0d data=%h required %b %0d %h",
                   exp, l0, i0, d0, exp == 63, exp, sample_of(6'(exp)));
        end
        exp++;
      end
      stalled = v0 && !out_ready;
      held = {v0, l0, i0, d0};
      tick;
    end
    checks++;
    if (exp != 64 || {done0, busy0} !== 2'b10) begin
      errors++;
      $display("FAIL bp_complete got transfers=%0d done=%b busy=%b required 64 1 0", exp, done0, busy0);
    end
    out_ready = 1'b1;
    repeat (4) tick;
  endtask

  task automatic test_reset_mid;
    int found, bad;
    found = 0;
    bad = 0;
    out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (v0 && i0 == 6'd20) begin
        found = 1;
        break;
      end
      tick;
    end
    out_ready = 1'b0;
    tick;
    checks++;
    if (found == 0 || {v0, i0} !== {1'b1, 6'd20}) begin
      errors++;
      $display("FAIL pending_20 got found=%0d v=%b idx=%0d required 1 1 20", found, v0, i0);
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({v0, busy0, done0} !== 3'b000) begin
      errors++;
      $display("FAIL abort_reset got v=%b busy=%b done=%b required 0 0 0", v0, busy0, done0);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (70) begin
      tick;
      if (done0 || v0 || busy0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_done_after_abort got %0d active cycles required 0", bad);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    checks++;
    if ({v0, i0, d0} !== {1'b1, 6'd0, sample_of(6'd0)}) begin
      errors++;
      $display("FAIL restart_index got v=%b idx=%0d data=%h required 1 0 %h", v0, i0, d0, sample_of(6'd0));
    end
    for (int n = 0; n < 200 && !done0; n++) tick;
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL restart_done got done=%b required 1", done0);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int exp;
    exp = 0;
    out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    for (int n = 0; n < 200 && exp < 64; n++) begin
      checks++;
      if ({v0, i0} !== {1'b1, 6'(exp)}) begin
        errors++;
        $display("FAIL ignore_start_pos%0d got v=%b idx=%0d required 1 %0d", exp, v0, i0, exp);
      end
      start = (i0 == 6'd30);
      exp++;
      tick;
    end
    start = 1'b0;
    checks++;
    if ({done0, busy0} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_first_done got done=%b busy=%b required 1 0", done0, busy0);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if ({busy0, v0, done0} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b v=%b done=%b required 1 0 0", busy0, v0, done0);
    end
    tick;
    checks++;
    if ({v0, i0} !== {1'b1, 6'd0}) begin
      errors++;
      $display("FAIL b2b_first_sample got v=%b idx=%0d required 1 0", v0, i0);
    end
    for (int n = 0; n < 200 && !done0; n++) tick;
    checks++;
    if (done0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done got done=%b required 1", done0);
    end
    tick;
  endtask

  initial begin
    for (int p = 0; p < 64; p++) begin
      logic [5:0] pp;
      pp = 6'(p);
      if (^pp) mem_b1[pp[5:1]] = sample_of(pp);
      else     mem_b0[pp[5:1]] = sample_of(pp);
    end
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    test_reset;
    test_stream_orders;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
